// File: rtl/peak_detect_ctrl.sv
// Peak-detect acquisition controller: admits 4-sample groups into the
// min/max tree, folds results per decimation window, queues (max,min) pairs.
module peak_detect_ctrl #(
  parameter int TREE_LAT  = 2,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] decim,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       t_max,
  input  logic [7:0]       t_min,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_max,
  output logic [7:0]       m_min,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int TW = 2 * CNT_W;

  localparam logic [CW-1:0] LP_THR =
    CW'(OUT_DEPTH - TREE_LAT - 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LP_LAST  = PW'(OUT_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]    r_decim;
  logic [CNT_W-1:0]    r_grp_cnt;
  logic [TW-1:0]       r_target;
  logic [TW-1:0]       r_acc_total;
  logic [TREE_LAT-1:0] r_vpipe;
  logic [7:0]          r_acc_max;
  logic [7:0]          r_acc_min;
  logic                r_overflow;

  logic [7:0]    r_mem_max [OUT_DEPTH];
  logic [7:0]    r_mem_min [OUT_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [CNT_W-1:0] w_decim_eff;
  logic [TW-1:0]    w_acc_total_nxt;
  logic [7:0]       w_fold_max;
  logic [7:0]       w_fold_min;
  logic w_start;
  logic w_accept;
  logic w_retire;
  logic w_first;
  logic w_last;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

  assign w_decim_eff =
    (decim == '0) ? CNT_W'(1) : decim;
  assign w_start =
    start && !abort && (r_state == S_IDLE);

  assign s_ready =
    (r_state == S_RUN) && (r_count < LP_THR);
  assign w_accept = s_valid && s_ready;
  assign w_acc_total_nxt = r_acc_total + TW'(1);

  assign w_retire = r_vpipe[TREE_LAT-1];
  assign w_first  = (r_grp_cnt == '0);
  assign w_last   =
    (r_grp_cnt == r_decim - CNT_W'(1));

  // First result of a window seeds the accumulator.
  assign w_fold_max =
    (w_first || t_max > r_acc_max) ? t_max : r_acc_max;
  assign w_fold_min =
    (w_first || t_min < r_acc_min) ? t_min : r_acc_min;

  assign w_push = w_retire && w_last;
  assign w_pop  = m_valid && m_ready;
  assign w_full = (r_count == LP_DEPTH);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start)
          w_state_nxt = (num_pairs == '0) ?
                        S_DONE : S_RUN;
      S_RUN:
        if (w_accept &&
            w_acc_total_nxt == r_target)
          w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (r_vpipe == '0 &&
            r_grp_cnt == '0 &&
            r_count == '0)
          w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
    if (abort)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decim     <= '0;
      r_grp_cnt   <= '0;
      r_target    <= '0;
      r_acc_total <= '0;
      r_vpipe     <= '0;
      r_acc_max   <= '0;
      r_acc_min   <= '0;
      r_overflow  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem_max[i] <= '0;
        r_mem_min[i] <= '0;
      end
    end else if (abort) begin
      r_grp_cnt   <= '0;
      r_acc_total <= '0;
      r_vpipe     <= '0;
      r_acc_max   <= '0;
      r_acc_min   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_vpipe[0] <= w_accept;
      for (int i = 1; i < TREE_LAT; i++)
        r_vpipe[i] <= r_vpipe[i-1];

      if (w_accept)
        r_acc_total <= w_acc_total_nxt;

      if (w_retire) begin
        r_acc_max <= w_fold_max;
        r_acc_min <= w_fold_min;
        r_grp_cnt <= w_last ? '0 :
                     r_grp_cnt + CNT_W'(1);
      end

      if (w_push && !w_wr)
        r_overflow <= 1'b1;

      if (w_wr) begin
        r_mem_max[r_wptr] <= w_fold_max;
        r_mem_min[r_wptr] <= w_fold_min;
        r_wptr <= (r_wptr == LP_LAST) ? '0 :
                  r_wptr + PW'(1);
      end

      if (w_pop)
        r_rptr <= (r_rptr == LP_LAST) ? '0 :
                  r_rptr + PW'(1);

      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Start takes priority over any leftover state.
      if (w_start) begin
        r_decim     <= w_decim_eff;
        r_target    <= {{CNT_W{1'b0}}, w_decim_eff} *
                       {{CNT_W{1'b0}}, num_pairs};
        r_acc_total <= '0;
        r_grp_cnt   <= '0;
        r_overflow  <= 1'b0;
      end
    end
  end

  assign m_valid  = (r_count != '0);
  assign m_max    = r_mem_max[r_rptr];
  assign m_min    = r_mem_min[r_rptr];
  assign busy     = (r_state == S_RUN) ||
                    (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;

endmodule
